modular_divider: RTL and testbench

- Sequential restoring divider for key generation. It is the inverse of the shift-add multiplier.
- Takes a 2*WIDTH-bit dividend and a WIDTH-bit divisor. Produces a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Computes one quotient bit per clock.
- Used to reduce multiplier products modulo a key modulus, and for quotient/remainder steps during key derivation.

---
 rtl/modular_divider_if.sv | 27 ++
 rtl/modular_divider.sv | 120 ++++++++++++
 tb/tb_modular_divider.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/modular_divider_if.sv
// Operand/result bundle for the restoring divider: request side (operands, start
// strobe) and result side (quotient, remainder, flags).
interface modular_divider_if #(
  parameter int WIDTH = 256
);
  // start_valid is a request strobe, honoured only while busy is low; no ready is
  // returned, busy=0 is the acceptance condition. result_valid pulses for one
  // cycle when quotient/remainder/div_zero carry a fresh result.
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               start_valid;
  logic [2*WIDTH-1:0] quotient;
  logic [WIDTH-1:0]   remainder;
  logic               div_zero;
  logic               result_valid;
  logic               busy;

  modport master (
    output dividend, divisor, start_valid,
    input  quotient, remainder, div_zero, result_valid, busy
  );

  modport slave (
    input  dividend, divisor, start_valid,
    output quotient, remainder, div_zero, result_valid, busy
  );
endinterface

// File: rtl/modular_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, with divide-by-zero short-circuit.
module modular_divider #(
  parameter int WIDTH = 256
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  modular_divider_if.slave   bus,
  output logic [1:0]         dbg_state
);
  localparam int CNT_W = $clog2(2 * WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(2 * WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTING = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [2*WIDTH-1:0] dividend_sr;
  logic [2*WIDTH-1:0] quo_sr;
  logic [WIDTH-1:0]   divisor_r;
  logic [WIDTH-1:0]   rem;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] quo_next;
  logic               last_iter;

  // The shifted remainder needs the extra top bit: when the divisor MSB is set the
  // shifted value can exceed 2^WIDTH-1. After the restore step it always fits in
  // WIDTH bits, so only WIDTH bits are stored and the subtraction is done modulo 2^WIDTH.
  always_comb begin
    rem_shift = {rem, dividend_sr[2*WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, divisor_r};
    rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - divisor_r) : rem_shift[WIDTH-1:0];
    quo_next  = {quo_sr[2*WIDTH-2:0], rem_ge};
    last_iter = (cnt == LAST_ITER);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start_valid) begin
          next_state = (bus.divisor == '0) ? DONE : COMPUTING;
        end
      end
      COMPUTING: begin
        if (last_iter) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // result_valid is registered from the DONE state, so the pulse lands one edge
  // after DONE is entered, coinciding with busy falling.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      dividend_sr      <= '0;
      quo_sr           <= '0;
      divisor_r        <= '0;
      rem              <= '0;
      cnt              <= '0;
      bus.quotient     <= '0;
      bus.remainder    <= '0;
      bus.div_zero     <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.busy         <= (next_state != IDLE);
      bus.result_valid <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            dividend_sr <= bus.dividend;
            divisor_r   <= bus.divisor;
            rem         <= '0;
            quo_sr      <= '0;
            cnt         <= '0;
            if (bus.divisor == '0) begin
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend[WIDTH-1:0];
              bus.div_zero  <= 1'b1;
            end
          end
        end
        COMPUTING: begin
          dividend_sr <= {dividend_sr[2*WIDTH-2:0], 1'b0};
          rem         <= rem_next;
          quo_sr      <= quo_next;
          cnt         <= cnt + CNT_W'(1);
          if (last_iter) begin
            bus.quotient  <= quo_next;
            bus.remainder <= rem_next;
            bus.div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_modular_divider.sv
// Bench for modular_divider: WIDTH=8 instance checked every cycle against an
// arithmetic model, plus a WIDTH=256 instance checked per operation.
module tb_modular_divider;
  logic clk = 1'b0;
  logic rst8 = 1'b0;
  logic rst256 = 1'b0;
  logic [1:0] dbg8;
  logic [1:0] dbg256;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  modular_divider_if #(.WIDTH(8))   if8 ();
  modular_divider_if #(.WIDTH(256)) if256 ();

  modular_divider #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_n_in(rst8), .bus(if8), .dbg_state(dbg8)
  );
  modular_divider #(.WIDTH(256)) dut256 (
    .clk_in(clk), .rst_n_in(rst256), .bus(if256), .dbg_state(dbg256)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the WIDTH=8 instance: division by plain arithmetic, timing from the
  // externally visible contract (result 2W+1 edges after accept, 1 edge for /0).
  bit          m_pending = 0;
  int          m_due = 0;
  logic [15:0] m_a = '0, m_q = '0;
  logic [7:0]  m_b = '0, m_r = '0;
  bit          m_dz = 0;
  bit          e_valid = 0, e_busy = 0, e_dz = 0;
  logic [15:0] e_quo = '0;
  logic [7:0]  e_rem = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst8) begin
      m_pending <= 0; e_valid <= 0; e_busy <= 0;
      e_quo <= '0; e_rem <= '0; e_dz <= 0;
    end else begin
      e_valid <= 0;
      if (m_pending && (cyc + 1 == m_due)) begin
        m_pending <= 0; e_valid <= 1; e_busy <= 0;
        e_quo <= m_q; e_rem <= m_r; e_dz <= m_dz;
      end else if (!m_pending && if8.start_valid) begin
        m_pending <= 1; e_busy <= 1;
        m_a <= if8.dividend; m_b <= if8.divisor;
        if (if8.divisor == 8'd0) begin
          m_q <= 16'hFFFF; m_r <= if8.dividend[7:0]; m_dz <= 1;
          m_due <= cyc + 1 + 1;
        end else begin
          m_q <= if8.dividend / {8'd0, if8.divisor};
          m_r <= 8'(if8.dividend % {8'd0, if8.divisor});
          m_dz <= 0;
          m_due <= cyc + 1 + 17;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("valid8", if8.result_valid, e_valid);
      chk("busy8", if8.busy, e_busy);
      if (!e_busy) begin
        chk("quo8", if8.quotient, e_quo);
        chk("rem8", if8.remainder, e_rem);
        chk("dz8", if8.div_zero, e_dz);
      end
      if (e_valid && !e_dz) begin
        chk("inv_qdr8", 32'(if8.quotient) * 32'(m_b) + 32'(if8.remainder), 32'(m_a));
        chk("inv_rlt8", if8.remainder < m_b, 1'b1);
      end
    end
  end

  task automatic op8(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                     input logic [7:0] er, input bit edz, input int elat);
    int acc;
    bit seen;
    @(posedge clk); #2;
    if8.dividend = a; if8.divisor = b; if8.start_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    #1;
    if8.start_valid = 1'b0;
    if8.dividend = 16'($urandom); if8.divisor = 8'($urandom);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (if8.result_valid) seen = 1;
    end
    chk("lit_seen", seen, 1'b1);
    chk("lit_latency", cyc - acc, elat);
    chk("lit_quo", if8.quotient, eq);
    chk("lit_rem", if8.remainder, er);
    chk("lit_dz", if8.div_zero, edz);
    @(posedge clk); #1;
    chk("lit_pulse_width", if8.result_valid, 1'b0);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic op256(input logic [511:0] a, input logic [255:0] b);
    bit seen;
    logic [511:0] eq;
    logic [255:0] er;
    logic [767:0] recon;
    @(posedge clk); #2;
    if256.dividend = a; if256.divisor = b; if256.start_valid = 1'b1;
    @(posedge clk); #2;
    if256.start_valid = 1'b0;
    if256.dividend = rnd512(); if256.divisor = rnd512()[255:0];
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk); #1;
      if (if256.result_valid) seen = 1;
    end
    chk("w256_seen", seen, 1'b1);
    if (b == '0) begin
      eq = '1; er = a[255:0];
    end else begin
      eq = a / {256'd0, b};
      er = 256'(a % {256'd0, b});
    end
    chk("w256_quo", if256.quotient, eq);
    chk("w256_rem", if256.remainder, er);
    chk("w256_dz", if256.div_zero, b == '0);
    if (b != '0) begin
      recon = {256'd0, if256.quotient} * {512'd0, b} + {512'd0, if256.remainder};
      chk("w256_inv_qdr", recon == {256'd0, a}, 1'b1);
      chk("w256_inv_rlt", if256.remainder < b, 1'b1);
    end
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int cnt;
    logic [511:0] a;
    logic [255:0] b;
    if8.dividend = '0; if8.divisor = '0; if8.start_valid = 1'b0;
    if256.dividend = '0; if256.divisor = '0; if256.start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quo", if8.quotient, 16'h0);
    chk("rst_rem", if8.remainder, 8'h0);
    chk("rst_dz", if8.div_zero, 1'b0);
    chk("rst_valid", if8.result_valid, 1'b0);
    chk("rst_busy", if8.busy, 1'b0);
    chk("rst_busy256", if256.busy, 1'b0);
    #1;
    rst8 = 1'b1; rst256 = 1'b1;

    op8(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 17);
    op8(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 17);
    op8(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17);
    op8(16'h0005, 8'hC8, 16'h0000, 8'h05, 1'b0, 17);
    op8(16'hFFFE, 8'h80, 16'h01FF, 8'h7E, 1'b0, 17);
    op8(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1);
    op8(16'h0010, 8'h04, 16'h0004, 8'h00, 1'b0, 17);

    // start held high with operands changing every cycle: one result per 18 edges
    @(posedge clk); #2;
    if8.start_valid = 1'b1;
    if8.dividend = 16'($urandom); if8.divisor = 8'($urandom_range(1, 255));
    cnt = 0;
    for (int i = 0; i < 54; i++) begin
      @(posedge clk); #1;
      if (if8.result_valid) cnt++;
      #1;
      if8.dividend = 16'($urandom); if8.divisor = 8'($urandom_range(1, 255));
      if (i == 53) if8.start_valid = 1'b0;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("held_result_count", cnt, 3);

    // a start strobe seen only in the DONE cycle must be dropped
    #1;
    if8.dividend = 16'd500; if8.divisor = 8'd9; if8.start_valid = 1'b1;
    @(posedge clk); #2;
    if8.start_valid = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    if8.dividend = 16'h0010; if8.divisor = 8'h04; if8.start_valid = 1'b1;
    @(posedge clk); #2;
    if8.start_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (if8.result_valid || if8.busy) cnt++;
    end
    chk("done_cycle_ignored", cnt, 0);
    chk("done_cycle_quo", if8.quotient, 16'd55);
    chk("done_cycle_rem", if8.remainder, 8'd5);

    // reset part-way through 100/3 aborts it
    @(posedge clk); #2;
    if8.dividend = 16'd100; if8.divisor = 8'd3; if8.start_valid = 1'b1;
    @(posedge clk); #2;
    if8.start_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_quo", if8.quotient, 16'h0);
    chk("abort_rem", if8.remainder, 8'h0);
    chk("abort_valid", if8.result_valid, 1'b0);
    chk("abort_busy", if8.busy, 1'b0);
    #1;
    rst8 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_result", if8.result_valid, 1'b0);
    op8(16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 17);

    // WIDTH=256 instance
    for (int k = 0; k < 16; k++) begin
      a = rnd512();
      b = rnd512()[255:0];
      case (k)
        0: b = 256'd1;
        1: b[255] = 1'b1;
        2: begin a = '1; b = 256'd1; end
        3: begin a = '1; b = '1; end
        4: b = '0;
        5: a = {256'd0, 256'd17};
        6: begin b[255] = 1'b1; a[511] = 1'b1; end
        default: if (b == '0) b = 256'd3;
      endcase
      op256(a, b);
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
